// File: rtl/punc_ctrl_pkg.sv
// ============================================================================
// Module      : punc_ctrl_pkg
// Description : Opcodes, FSM state encoding and datapath select encodings
//               shared by the PUnC control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package punc_ctrl_pkg;

    localparam logic [3:0] C_OP_BR   = 4'b0000;
    localparam logic [3:0] C_OP_ADD  = 4'b0001;
    localparam logic [3:0] C_OP_LD   = 4'b0010;
    localparam logic [3:0] C_OP_ST   = 4'b0011;
    localparam logic [3:0] C_OP_JSR  = 4'b0100;
    localparam logic [3:0] C_OP_AND  = 4'b0101;
    localparam logic [3:0] C_OP_LDR  = 4'b0110;
    localparam logic [3:0] C_OP_STR  = 4'b0111;
    localparam logic [3:0] C_OP_ILL8 = 4'b1000;
    localparam logic [3:0] C_OP_NOT  = 4'b1001;
    localparam logic [3:0] C_OP_LDI  = 4'b1010;
    localparam logic [3:0] C_OP_STI  = 4'b1011;
    localparam logic [3:0] C_OP_JMP  = 4'b1100;
    localparam logic [3:0] C_OP_ILLD = 4'b1101;
    localparam logic [3:0] C_OP_LEA  = 4'b1110;
    localparam logic [3:0] C_OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] C_ADDR_PC    = 2'b00;
    localparam logic [1:0] C_ADDR_ALU   = 2'b01;
    localparam logic [1:0] C_ADDR_STORE = 2'b10;

    localparam logic [1:0] C_WSEL_PC    = 2'b00;
    localparam logic [1:0] C_WSEL_MEM   = 2'b01;
    localparam logic [1:0] C_WSEL_ALU   = 2'b10;

    localparam logic [1:0] C_ALU_ADD    = 2'b00;
    localparam logic [1:0] C_ALU_AND    = 2'b01;
    localparam logic [1:0] C_ALU_PASS   = 2'b10;
    localparam logic [1:0] C_ALU_NOT    = 2'b11;

    localparam logic       C_ASEL_PC    = 1'b0;
    localparam logic       C_ASEL_RF    = 1'b1;
    localparam logic       C_BSEL_RF    = 1'b0;
    localparam logic       C_BSEL_IMM   = 1'b1;

    localparam logic       C_NZP_ALU    = 1'b0;
    localparam logic       C_NZP_MEM    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/punc_imm_gen.sv
// ============================================================================
// Module      : punc_imm_gen
// Description : Picks the immediate field implied by the opcode and
//               sign-extends it to 16 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_imm_gen
    import punc_ctrl_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  logic [11:0] i_ir,
    output logic [15:0] o_imm
);

    always_comb begin
        o_imm = {{7{i_ir[8]}}, i_ir[8:0]};
        case (i_opcode)
            C_OP_ADD, C_OP_AND: o_imm = {{11{i_ir[4]}}, i_ir[4:0]};
            C_OP_LDR, C_OP_STR: o_imm = {{10{i_ir[5]}}, i_ir[5:0]};
            C_OP_JSR: begin
                // JSRR uses no immediate; off11 only matters for the PC-relative form.
                if (i_ir[11]) begin
                    o_imm = {{5{i_ir[10]}}, i_ir[10:0]};
                end
            end
            default: o_imm = {{7{i_ir[8]}}, i_ir[8:0]};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/punc_control_fsm.sv
// ============================================================================
// Module      : punc_control_fsm
// Description : Multi-cycle FETCH/DECODE/EXEC control unit for the PUnC LC3.
//               Macro PUNC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_control_fsm
    import punc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        ir_ld,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic [2:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [1:0]  rf_w_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_sel,
    output logic [15:0] sext_data,
    output logic        nzp_ld,
    output logic        nzp_sel,
    output logic        store_ld,
    output logic        halted
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  w_opcode;
    logic [15:0] w_imm;
    logic        w_sext_en;
    logic        w_br_taken;

    assign w_opcode   = ir[15:12];
    assign w_br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign sext_data  = w_sext_en ? w_imm : 16'h0000;

    punc_imm_gen u_imm_gen (
        .i_opcode (w_opcode),
        .i_ir     (ir[11:0]),
        .o_imm    (w_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sext_en    = 1'b0;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        ir_ld        = 1'b0;
        mem_addr_sel = C_ADDR_PC;
        mem_w_en     = 1'b0;
        rf_r_addr_0  = 3'd0;
        rf_r_addr_1  = 3'd0;
        rf_w_addr    = 3'd0;
        rf_w_en      = 1'b0;
        rf_w_sel     = C_WSEL_PC;
        alu_a_sel    = C_ASEL_PC;
        alu_b_sel    = C_BSEL_RF;
        alu_sel      = C_ALU_ADD;
        nzp_ld       = 1'b0;
        nzp_sel      = C_NZP_ALU;
        store_ld     = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_RESET: begin
                pc_clr = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_EXEC1;
                if (w_opcode == C_OP_TRAP) begin
                    w_next = S_HALT;
                end
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
                if ((w_opcode == C_OP_ILL8) || (w_opcode == C_OP_ILLD)) begin
                    w_next = S_HALT;
                end
`endif
            end
            S_EXEC1: begin
                w_next = S_FETCH;
                case (w_opcode)
                    C_OP_ADD, C_OP_AND: begin
                        rf_r_addr_0 = ir[8:6];
                        alu_a_sel   = C_ASEL_RF;
                        alu_sel     = (w_opcode == C_OP_AND) ? C_ALU_AND : C_ALU_ADD;
                        if (ir[5]) begin
                            alu_b_sel = C_BSEL_IMM;
                            w_sext_en = 1'b1;
                        end else begin
                            rf_r_addr_1 = ir[2:0];
                        end
                        rf_w_addr = ir[11:9];
                        rf_w_en   = 1'b1;
                        rf_w_sel  = C_WSEL_ALU;
                        nzp_ld    = 1'b1;
                    end
                    C_OP_NOT: begin
                        rf_r_addr_0 = ir[8:6];
                        alu_a_sel   = C_ASEL_RF;
                        alu_sel     = C_ALU_NOT;
                        rf_w_addr   = ir[11:9];
                        rf_w_en     = 1'b1;
                        rf_w_sel    = C_WSEL_ALU;
                        nzp_ld      = 1'b1;
                    end
                    C_OP_BR: begin
                        if (w_br_taken) begin
                            alu_b_sel = C_BSEL_IMM;
                            w_sext_en = 1'b1;
                            pc_ld     = 1'b1;
                        end
                    end
                    C_OP_JMP: begin
                        rf_r_addr_0 = ir[8:6];
                        alu_a_sel   = C_ASEL_RF;
                        alu_sel     = C_ALU_PASS;
                        pc_ld       = 1'b1;
                    end
                    C_OP_JSR: begin
                        // R7 capture and PC load share one edge, so JSRR R7 jumps to the old R7.
                        rf_w_addr = 3'd7;
                        rf_w_en   = 1'b1;
                        pc_ld     = 1'b1;
                        if (ir[11]) begin
                            alu_b_sel = C_BSEL_IMM;
                            w_sext_en = 1'b1;
                        end else begin
                            rf_r_addr_0 = ir[8:6];
                            alu_a_sel   = C_ASEL_RF;
                            alu_sel     = C_ALU_PASS;
                        end
                    end
                    C_OP_LEA: begin
                        alu_b_sel = C_BSEL_IMM;
                        w_sext_en = 1'b1;
                        rf_w_addr = ir[11:9];
                        rf_w_en   = 1'b1;
                        rf_w_sel  = C_WSEL_ALU;
                    end
                    C_OP_LD, C_OP_LDR, C_OP_ST, C_OP_STR, C_OP_LDI, C_OP_STI: begin
                        mem_addr_sel = C_ADDR_ALU;
                        alu_b_sel    = C_BSEL_IMM;
                        w_sext_en    = 1'b1;
                        if ((w_opcode == C_OP_LDR) || (w_opcode == C_OP_STR)) begin
                            rf_r_addr_0 = ir[8:6];
                            alu_a_sel   = C_ASEL_RF;
                        end
                        case (w_opcode)
                            C_OP_LD, C_OP_LDR: begin
                                rf_w_addr = ir[11:9];
                                rf_w_en   = 1'b1;
                                rf_w_sel  = C_WSEL_MEM;
                                nzp_ld    = 1'b1;
                                nzp_sel   = C_NZP_MEM;
                            end
                            C_OP_ST, C_OP_STR: begin
                                rf_r_addr_1 = ir[11:9];
                                mem_w_en    = 1'b1;
                            end
                            default: begin
                                store_ld = 1'b1;
                                w_next   = S_EXEC2;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
            S_EXEC2: begin
                w_next       = S_FETCH;
                mem_addr_sel = C_ADDR_STORE;
                if (w_opcode == C_OP_LDI) begin
                    rf_w_addr = ir[11:9];
                    rf_w_en   = 1'b1;
                    rf_w_sel  = C_WSEL_MEM;
                    nzp_ld    = 1'b1;
                    nzp_sel   = C_NZP_MEM;
                end else begin
                    rf_r_addr_1 = ir[11:9];
                    mem_w_en    = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

endmodule

`default_nettype wire
